// File: rtl/sync_event_pkg.sv
// Shared constants and helpers for the event-capture block.
package sync_event_pkg;

  localparam int unsigned STATUS_W = 32;

  // Counter read index width; never narrower than one bit.
  function automatic int unsigned calc_idx_w(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/event_cell.sv
// One monitored bit: level register, qualified edge detect, sticky flag and
// saturating event counter.
module event_cell #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             armed,
  input  logic             sync_in,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             clr,
  input  logic             clr_cnt,
  output logic             level,
  output logic             sticky,
  output logic             sticky_nxt_c,
  output logic [CNT_W-1:0] cnt
);

  logic             event_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Qualified edge against the previous sample; suppressed until armed.
  assign event_c = armed & ((rise_en & sync_in & ~level) |
                            (fall_en & ~sync_in & level));

  // Next sticky and counter values; an event wins over a same-cycle clear.
  always_comb begin
    sticky_nxt_c = sticky;
    cnt_nxt_c    = cnt;
    if (clr) begin
      sticky_nxt_c = 1'b0;
    end
    if (event_c) begin
      sticky_nxt_c = 1'b1;
    end
    if (clr && clr_cnt) begin
      cnt_nxt_c = event_c ? CNT_W'(1) : '0;
    end else if (event_c && !(&cnt)) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end
  end

  // Per-bit state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level  <= 1'b0;
      sticky <= 1'b0;
      cnt    <= '0;
    end else begin
      level  <= sync_in;
      sticky <= sticky_nxt_c;
      cnt    <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/sync_event_capture.sv
// Event capture over a bank of synchronized levels: per-bit edge detect,
// sticky flags, counters, interrupt reduction and an indexed counter read.
module sync_event_capture
  import sync_event_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned IDX_W = calc_idx_w(WIDTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    sync_in,
  input  logic [WIDTH-1:0]    rise_en,
  input  logic [WIDTH-1:0]    fall_en,
  input  logic [WIDTH-1:0]    irq_mask,
  input  logic                clr_stb,
  input  logic [WIDTH-1:0]    clr_mask,
  input  logic                clr_cnt,
  input  logic                rd_stb,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [STATUS_W-1:0] status,
  output logic                irq,
  output logic                rd_valid,
  output logic [CNT_W-1:0]    rd_data
);

  // Parameter range checks at elaboration.
  if (WIDTH < 1 || 2 * WIDTH > STATUS_W) begin : g_bad_width
    $error("sync_event_capture: WIDTH out of range");
  end
  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    $error("sync_event_capture: CNT_W out of range");
  end

  logic                armed;
  logic [WIDTH-1:0]    level;
  logic [WIDTH-1:0]    sticky;
  logic [WIDTH-1:0]    sticky_nxt;
  logic [CNT_W-1:0]    cnt [WIDTH];
  logic [CNT_W-1:0]    rd_sel_c;

  // Per-bit capture cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    event_cell #(
      .CNT_W(CNT_W)
    ) u_cell (
      .clk         (clk),
      .resetn      (resetn),
      .armed       (armed),
      .sync_in     (sync_in[i]),
      .rise_en     (rise_en[i]),
      .fall_en     (fall_en[i]),
      .clr         (clr_stb & clr_mask[i]),
      .clr_cnt     (clr_cnt),
      .level       (level[i]),
      .sticky      (sticky[i]),
      .sticky_nxt_c(sticky_nxt[i]),
      .cnt         (cnt[i])
    );
  end

  // Status word is a straight concatenation of registered state.
  assign status = STATUS_W'({sticky, level});

  // Arm one cycle after reset so levels already high do not look like edges.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Interrupt follows the next-state sticky bits under the current mask.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(sticky_nxt & irq_mask);
    end
  end

  // Counter read mux; indices beyond WIDTH read as zero.
  always_comb begin
    rd_sel_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (32'(rd_idx) == i) begin
        rd_sel_c = cnt[i];
      end
    end
  end

  // Read response register; samples counters before their same-cycle update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_stb;
      if (rd_stb) begin
        rd_data <= rd_sel_c;
      end
    end
  end

endmodule
